// File: rtl/edit_sequencer.sv
// Key conditioning (sync, debounce, press detect, optional auto-repeat) and edit-field FSM for the clock front end.
// Optional auto-repeat of plus/minus strobes is built only when AUTO_REPEAT_EN is defined.
module edit_sequencer #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000,
  parameter int BLINK_HALF_CYC   = 12_500_000,
  parameter int TIMEOUT_S        = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_edit_n,
  input  logic       key_plus_n,
  input  logic       key_minus_n,
  input  logic       key_swi_n,
  input  logic       sec_tick,
  output logic       edit_mode,
  output logic [2:0] field_sel,
  output logic       inc_stb,
  output logic       dec_stb,
  output logic       blink_on,
  output logic [1:0] screen_sel
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BL_W = $clog2(BLINK_HALF_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_E_MIN   = 3'd1;
  localparam logic [2:0] S_E_HOUR  = 3'd2;
  localparam logic [2:0] S_E_DAY   = 3'd3;
  localparam logic [2:0] S_E_MONTH = 3'd4;
  localparam logic [2:0] S_E_YEAR  = 3'd5;

  // Key bit order: 0=edit, 1=plus, 2=minus, 3=swi
  logic [3:0]      w_raw;
  logic [3:0]      r_sync1, r_sync2, r_db, r_db_d;
  logic [3:0]      w_press;
  logic [DB_W-1:0] r_db_cnt [4];

  assign w_raw = {key_swi_n, key_minus_n, key_plus_n, key_edit_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_db_d  <= '1;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_db_d & ~r_db;

  logic            w_edit_p, w_plus_p, w_minus_p, w_swi_p;
  logic            w_in_edit, w_inc, w_dec, w_timeout, w_chg;
  logic            w_rep_inc, w_rep_dec;
  logic [2:0]      r_state, w_next;
  logic [TO_W-1:0] r_idle;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink, r_inc, r_dec, r_edit_mode;
  logic [1:0]      r_screen;

  assign w_edit_p  = w_press[0];
  assign w_plus_p  = w_press[1];
  assign w_minus_p = w_press[2];
  assign w_swi_p   = w_press[3];
  assign w_in_edit = (r_state != S_RUN);

  // Edit press outranks any strobe; plus and minus together cancel each other.
  assign w_inc = w_in_edit & ~w_edit_p & ((w_plus_p & ~w_minus_p) | w_rep_inc);
  assign w_dec = w_in_edit & ~w_edit_p & ((w_minus_p & ~w_plus_p) | w_rep_dec);
  assign w_timeout = w_in_edit & (r_idle >= TO_W'(TIMEOUT_S));

  always_comb begin
    w_next = r_state;
    if (w_edit_p) begin
      w_next = (r_state == S_E_YEAR) ? S_RUN : r_state + 3'd1;
    end else if (w_timeout && !w_inc && !w_dec) begin
      w_next = S_RUN;
    end
  end

  assign w_chg = (w_next != r_state);

`ifdef AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic            r_rep_arm, r_rep_phase;
  logic [RP_W-1:0] r_rep_cnt;
  logic            w_plus_held, w_minus_held, w_rep_due, w_press_stb;

  assign w_plus_held  = ~r_db[1] & r_db[2];
  assign w_minus_held = ~r_db[2] & r_db[1];
  assign w_press_stb  = w_in_edit & ~w_edit_p & (w_plus_p ^ w_minus_p);
  assign w_rep_due    = r_rep_arm & (r_rep_phase ? (r_rep_cnt == RP_W'(REPEAT_RATE_CYC - 1))
                                                 : (r_rep_cnt == RP_W'(REPEAT_DELAY_CYC - 1)));
  assign w_rep_inc    = w_rep_due & w_plus_held;
  assign w_rep_dec    = w_rep_due & w_minus_held;

  // Arming only on a real press strobe keeps a key carried into edit mode from repeating.
  always_ff @(posedge clk) begin
    if (rst || !w_in_edit || w_chg || !(w_plus_held || w_minus_held)) begin
      r_rep_arm   <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_press_stb) begin
      r_rep_arm   <= 1'b1;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (r_rep_arm) begin
      if (w_rep_due) begin
        r_rep_phase <= 1'b1;
        r_rep_cnt   <= '0;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
    end
  end
`else
  assign w_rep_inc = 1'b0;
  assign w_rep_dec = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_edit_mode <= 1'b0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_screen    <= 2'd0;
      r_idle      <= '0;
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_edit_mode <= (w_next != S_RUN);
      r_inc       <= w_inc;
      r_dec       <= w_dec;
      if (!w_in_edit && w_swi_p) r_screen <= r_screen + 2'd1;

      // Activity clears the idle count even when a second tick lands in the same cycle.
      if (!w_in_edit || w_chg || w_inc || w_dec) begin
        r_idle <= '0;
      end else if (sec_tick && r_idle < TO_W'(TIMEOUT_S)) begin
        r_idle <= r_idle + 1'b1;
      end

      if (w_next == S_RUN || w_chg || w_inc || w_dec) begin
        r_blink     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BL_W'(BLINK_HALF_CYC - 1)) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign field_sel  = r_state;
  assign edit_mode  = r_edit_mode;
  assign inc_stb    = r_inc;
  assign dec_stb    = r_dec;
  assign blink_on   = r_blink;
  assign screen_sel = r_screen;

  // Used with S_E_MIN..S_E_MONTH for readability of the state encoding.
  logic w_unused_codes;
  assign w_unused_codes = ^{S_E_MIN, S_E_HOUR, S_E_DAY, S_E_MONTH};

endmodule

// File: tb/tb_edit_sequencer.sv
// Directed bench for edit_sequencer with short debounce/blink/timeout/repeat parameters.
module tb_edit_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_edit_n = 1'b1, key_plus_n = 1'b1, key_minus_n = 1'b1, key_swi_n = 1'b1;
  logic       sec_tick = 1'b0;
  logic       edit_mode, inc_stb, dec_stb, blink_on;
  logic [2:0] field_sel;
  logic [1:0] screen_sel;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;
  int both_hi = 0;
  int inc_t[$];

  edit_sequencer #(
    .DEBOUNCE_CYC(4), .REPEAT_DELAY_CYC(20), .REPEAT_RATE_CYC(5),
    .BLINK_HALF_CYC(10), .TIMEOUT_S(3)
  ) dut (
    .clk(clk), .rst(rst),
    .key_edit_n(key_edit_n), .key_plus_n(key_plus_n),
    .key_minus_n(key_minus_n), .key_swi_n(key_swi_n),
    .sec_tick(sec_tick),
    .edit_mode(edit_mode), .field_sel(field_sel),
    .inc_stb(inc_stb), .dec_stb(dec_stb),
    .blink_on(blink_on), .screen_sel(screen_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inc_stb) begin
      inc_cnt++;
      inc_t.push_back(cyc);
    end
    if (dec_stb) dec_cnt++;
    if (inc_stb && dec_stb) both_hi++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_edit_n = v;
      1: key_plus_n = v;
      2: key_minus_n = v;
      default: key_swi_n = v;
    endcase
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b0);
    tick(hold);
    set_key(k, 1'b1);
    tick(10);
  endtask

  task automatic pulse_sec;
    sec_tick = 1'b1;
    tick(1);
    sec_tick = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_field", field_sel, 0);
    chk("rst_edit_mode", edit_mode, 0);
    chk("rst_inc", inc_stb, 0);
    chk("rst_dec", dec_stb, 0);
    chk("rst_blink", blink_on, 1);
    chk("rst_screen", screen_sel, 0);
    rst = 1'b0;
    tick(2);

    // Bounce then a clean low: accepted on the 7th edge after the final fall.
    key_edit_n = 1'b0; tick(2);
    key_edit_n = 1'b1; tick(1);
    key_edit_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk($sformatf("debounce_early_%0d", k), field_sel, 0);
    end
    tick(1);
    chk("debounce_field", field_sel, 1);
    chk("debounce_edit_mode", edit_mode, 1);
    key_edit_n = 1'b1;

    tick(9);
    chk("blink_pre_toggle", blink_on, 1);
    tick(1);
    chk("blink_toggle", blink_on, 0);
    tick(10);
    chk("blink_retoggle", blink_on, 1);

    press(0, 10);
    chk("field_hour", field_sel, 2);
    inc_cnt = 0; dec_cnt = 0;
    press(1, 10);
    press(1, 10);
    press(2, 10);
    chk("hour_inc_cycles", inc_cnt, 2);
    chk("hour_dec_cycles", dec_cnt, 1);

    for (int n = 3; n <= 6; n++) begin
      press(0, 10);
      chk($sformatf("edit_cycle_%0d", n), field_sel, n % 6);
    end
    chk("back_run_edit_mode", edit_mode, 0);

    for (int n = 1; n <= 5; n++) begin
      press(3, 10);
      chk($sformatf("swi_%0d", n), screen_sel, n % 4);
    end
    inc_cnt = 0;
    press(1, 10);
    chk("plus_in_run", inc_cnt, 0);
    press(0, 10);
    press(3, 10);
    chk("swi_in_edit", screen_sel, 1);
    chk("swi_in_edit_field", field_sel, 1);

    // Timeout: two ticks, a plus press, then three more ticks.
    press(0, 10);
    press(0, 10);
    chk("field_day", field_sel, 3);
    pulse_sec; tick(1);
    pulse_sec; tick(1);
    inc_cnt = 0; dec_cnt = 0;
    press(1, 10);
    chk("to_plus_inc", inc_cnt, 1);
    pulse_sec; tick(1);
    chk("to_tick1", field_sel, 3);
    pulse_sec; tick(1);
    chk("to_tick2", field_sel, 3);
    pulse_sec;
    chk("to_tick3", field_sel, 3);
    tick(1);
    chk("to_run", field_sel, 0);
    chk("to_edit_mode", edit_mode, 0);
    tick(3);
    chk("to_no_inc", inc_cnt, 1);
    chk("to_no_dec", dec_cnt, 0);

    // Long hold of plus in E_MIN.
    press(0, 10);
    chk("field_min_rep", field_sel, 1);
    inc_cnt = 0;
    inc_t.delete();
    key_plus_n = 1'b0;
    tick(40);
    key_plus_n = 1'b1;
    tick(20);
`ifdef AUTO_REPEAT_EN
    chk("rep_count", inc_cnt, 5);
    if (inc_t.size() == 5) begin
      chk("rep_off1", inc_t[1] - inc_t[0], 20);
      chk("rep_off2", inc_t[2] - inc_t[0], 25);
      chk("rep_off3", inc_t[3] - inc_t[0], 30);
      chk("rep_off4", inc_t[4] - inc_t[0], 35);
    end
`else
    chk("hold_single", inc_cnt, 1);
`endif

    inc_cnt = 0; dec_cnt = 0;
    key_plus_n = 1'b0; key_minus_n = 1'b0;
    tick(40);
    key_plus_n = 1'b1; key_minus_n = 1'b1;
    tick(20);
    chk("both_inc", inc_cnt, 0);
    chk("both_dec", dec_cnt, 0);

    // Reset in the middle of a hold in E_YEAR.
    for (int n = 0; n < 4; n++) press(0, 10);
    chk("field_year", field_sel, 5);
    key_plus_n = 1'b0;
    tick(12);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_field", field_sel, 0);
    chk("mid_rst_edit_mode", edit_mode, 0);
    chk("mid_rst_blink", blink_on, 1);
    chk("mid_rst_screen", screen_sel, 0);
    chk("mid_rst_inc", inc_stb, 0);
    chk("mid_rst_dec", dec_stb, 0);
    rst = 1'b0;
    inc_cnt = 0;
    tick(15);
    key_plus_n = 1'b1;
    tick(10);
    chk("post_rst_run_no_inc", inc_cnt, 0);
    chk("never_both", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/edit_sequencer.md
Name: edit_sequencer

Overview:
- Front-end controller for the digital clock's time-keeping and display datapath.
- Conditions the four active-low push buttons: 2-FF synchroniser, debounce, press detect, and auto-repeat.
- Runs the edit-mode state machine that selects which time field is being adjusted.
- Drives increment/decrement strobes, the blink phase and the screen selection consumed by the time counters and display mux.

Parameters:
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles before a key level change is accepted (20 ms at 50 MHz).
- REPEAT_DELAY_CYC, 25_000_000: held time after the first plus/minus strobe before auto-repeat starts.
- REPEAT_RATE_CYC, 5_000_000: auto-repeat strobe period.
- BLINK_HALF_CYC, 12_500_000: half-period of the edit-field blink.
- TIMEOUT_S, 30: idle seconds in edit mode before automatic return to RUN.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  synchronous, active-high reset
- key_edit_n  in  1  raw KEY[0], active low
- key_plus_n  in  1  raw KEY[1], active low
- key_minus_n  in  1  raw KEY[2], active low
- key_swi_n  in  1  raw KEY[3], active low
- sec_tick  in  1  one-cycle pulse per second from the time counter
- edit_mode  out  1  high in any edit state
- field_sel  out  3  0=RUN, 1=minutes, 2=hours, 3=day, 4=month, 5=year
- inc_stb  out  1  one-cycle increment request for the field_sel field
- dec_stb  out  1  one-cycle decrement request for the field_sel field
- blink_on  out  1  1 = show the selected field, 0 = blank it
- screen_sel  out  2  display page 0..3

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: field_sel=0, edit_mode=0, inc_stb=0, dec_stb=0, blink_on=1, screen_sel=0. Debounced key levels reset to 1 (released); all counters reset to 0.
- Per key:
  - 2-FF synchroniser, then debounce. The debounced level takes the synchronised value once that value has differed from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
  - A press is a debounced 1->0 transition.
  - Strobe latency is DEBOUNCE_CYC+3 clk edges from the first edge that samples the raw level low.
- A key held through reset produces one press after debounce. This is accepted behaviour.
- FSM states RUN, E_MIN, E_HOUR, E_DAY, E_MONTH, E_YEAR; field_sel equals the state code.
- edit press: RUN->E_MIN->E_HOUR->E_DAY->E_MONTH->E_YEAR->RUN.
- plus press: one-cycle inc_stb in edit states only; ignored in RUN.
- minus press: one-cycle dec_stb in edit states only; ignored in RUN.
- swi press: in RUN, screen_sel increments and wraps 3->0; ignored in edit states.
- Simultaneous events:
  - edit together with plus/minus in the same cycle: edit wins, no strobe.
  - plus and minus in the same cycle: both dropped.
  - inc_stb and dec_stb are never both high.
- Timeout:
  - The idle counter increments on sec_tick in edit states only.
  - It clears on any accepted press or repeat strobe, and on every state change.
  - A press and sec_tick in the same cycle: the clear wins.
  - When the count reaches TIMEOUT_S, the FSM enters RUN on the next cycle with no strobe.
- Blink:
  - In RUN, blink_on=1.
  - In edit states, blink_on toggles every BLINK_HALF_CYC cycles.
  - On state entry and on every inc_stb/dec_stb, blink_on is forced to 1 and the blink counter restarts.
- Auto-repeat timing counters clear on release, state change or rst.
- rst in the middle of a hold or edit aborts immediately to the reset values. A key still held afterwards re-qualifies as a new press.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While plus (or minus) stays debounced-low, one extra strobe fires REPEAT_DELAY_CYC cycles after the initial strobe, then one every REPEAT_RATE_CYC cycles.
  - Both keys held: no repeats.
  - Repeat strobes reset the timeout and blink like presses.
  - Leaving edit mode stops repeats.
- Undefined: exactly one strobe per press; repeat counters are absent from the netlist.

Test Plan:
- DEBOUNCE_CYC=4, rst then key_edit_n low 2 cycles, high 1, low 10 -> first press only after 4 stable cycles; field_sel 0->1 with edit_mode=1 at cycle 7 after the final low; no earlier change.
- Edit pressed 6 times -> field_sel 1,2,3,4,5,0; in E_HOUR, plus twice then minus once -> two inc_stb and one dec_stb, each exactly 1 cycle wide.
- In RUN, swi pressed 5 times -> screen_sel 1,2,3,0,1; plus in RUN -> no inc_stb; swi in E_MIN -> screen_sel unchanged.
- TIMEOUT_S=3, in E_DAY pulse sec_tick 2x, press plus, then 3x sec_tick -> stays E_DAY until 3rd tick after press, then field_sel=0, no strobe.
- AUTO_REPEAT_EN, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, hold plus 40 cycles in E_MIN -> strobes at t0, t0+20, +25, +30, +35; plus+minus held together -> zero strobes.
- rst asserted mid-hold in E_YEAR -> next cycle field_sel=0, blink_on=1, screen_sel=0, strobes 0.
